baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 151 +++++++++++++++
 tb/tb_baud_gen_frac.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator.
// A prescaler divides clk by act_int + act_frac/2^FRAC_W using a first-order
// fractional accumulator, giving oversample ticks. Every OVERSAMPLE ticks
// produces a bit tick, and the tick halfway through each bit produces a mid tick.
// Divisor writes are staged in a shadow register. They take effect at the next
// interval boundary or phase_clr, so no interval is ever cut short.
module baud_gen_frac #(
    parameter int FRE          = 50_000_000,
    parameter int OVERSAMPLE   = 16,
    parameter int INT_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int DEF_DIV_INT  = 325,
    parameter int DEF_DIV_FRAC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              phase_clr,
    input  logic              div_wr,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              div_pending,
    output logic              cfg_err
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int LIM_W = INT_W + 1;
    localparam logic [OS_W-1:0] MID_CNT = OS_W'(OVERSAMPLE / 2);

    // Parameter sanity checks, evaluated at elaboration only.
    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("baud_gen_frac: OVERSAMPLE must be a power of 2 and >= 4");
    end
    if (DEF_DIV_INT < 2) begin : g_bad_def
        $error("baud_gen_frac: DEF_DIV_INT must be >= 2");
    end
    if (FRE < 2 * OVERSAMPLE) begin : g_bad_fre
        $error("baud_gen_frac: FRE too low for the requested OVERSAMPLE");
    end

    // Active and shadow divisor.
    logic [INT_W-1:0]  act_int, sh_int;
    logic [FRAC_W-1:0] act_frac, sh_frac;
    logic              pending;

    // Prescaler state.
    logic [LIM_W-1:0]  lim, pcnt;
    logic [FRAC_W-1:0] acc;
    logic [OS_W-1:0]   os_cnt;

    // Registered outputs.
    logic os_q, mid_q, bit_q, err_q;

    // Combinational helpers.
    logic              boundary;
    logic              wr_ok;
    logic              apply;
    logic [INT_W-1:0]  eff_int;
    logic [FRAC_W-1:0] eff_frac;
    logic [FRAC_W:0]   acc_sum;
    logic [OS_W-1:0]   os_nxt;

    // Boundary detect, write qualification and the divisor used for the next interval.
    // A shadow value is applied only when it was pending before this edge, so a
    // boundary coinciding with the write still uses the old divisor.
    always_comb begin
        boundary = en && !phase_clr && (pcnt == lim - LIM_W'(1));
        wr_ok    = div_wr && (div_int >= INT_W'(2));
        apply    = pending && (boundary || phase_clr);
        eff_int  = apply ? sh_int  : act_int;
        eff_frac = apply ? sh_frac : act_frac;
        acc_sum  = {1'b0, acc} + {1'b0, eff_frac};
        os_nxt   = os_cnt + OS_W'(1);
    end

    // Shadow/active divisor registers and the pending flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_int  <= INT_W'(DEF_DIV_INT);
            act_frac <= FRAC_W'(DEF_DIV_FRAC);
            sh_int   <= INT_W'(DEF_DIV_INT);
            sh_frac  <= FRAC_W'(DEF_DIV_FRAC);
            pending  <= 1'b0;
        end else begin
            if (apply) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
            end
            if (wr_ok) begin
                sh_int  <= div_int;
                sh_frac <= div_frac;
            end
            // A write landing on an apply edge stays pending for the next event.
            if (wr_ok) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // Prescaler, fractional accumulator and oversample counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt   <= '0;
            acc    <= '0;
            os_cnt <= '0;
            lim    <= LIM_W'(DEF_DIV_INT);
        end else if (phase_clr) begin
            // Realign: the first interval is the bare integer divisor, no carry.
            pcnt   <= '0;
            acc    <= '0;
            os_cnt <= '0;
            lim    <= {1'b0, eff_int};
        end else if (en) begin
            if (boundary) begin
                pcnt   <= '0;
                acc    <= acc_sum[FRAC_W-1:0];
                os_cnt <= os_nxt;
                lim    <= {1'b0, eff_int} + {{INT_W{1'b0}}, acc_sum[FRAC_W]};
            end else begin
                pcnt <= pcnt + LIM_W'(1);
            end
        end
    end

    // One-cycle tick and error pulses, registered off the boundary edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_q  <= 1'b0;
            mid_q <= 1'b0;
            bit_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            os_q  <= boundary;
            mid_q <= boundary && (os_nxt == MID_CNT);
            bit_q <= boundary && (os_nxt == '0);
            err_q <= div_wr && !wr_ok;
        end
    end

    assign os_tick     = os_q;
    assign mid_tick    = mid_q;
    assign bit_tick    = bit_q;
    assign div_pending = pending;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac. The driver pushes the expected gap (in cycles since
// the previous os_tick or realign point) plus mid/bit flags for every os_tick.
// The negedge monitor pops one entry per os_tick and compares it.
module tb_baud_gen_frac;

    localparam int INT_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic              phase_clr = 1'b0;
    logic              div_wr = 1'b0;
    logic [INT_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              os_tick, mid_tick, bit_tick, div_pending, cfg_err;

    int n_vec = 0;
    int n_err = 0;

    // Expected os_tick entries: [33]=mid, [32]=bit, [31:0]=gap in cycles.
    logic [33:0] exp_q[$];
    int k_model = 0;

    int   cyc = 0;
    int   last_tick = 0;
    int   span_last = 0;
    int   last_ref = 0;
    logic ref_at_edge = 1'b0;

    int frac_gaps[16] = '{4, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4};

    baud_gen_frac dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .phase_clr   (phase_clr),
        .div_wr      (div_wr),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .os_tick     (os_tick),
        .mid_tick    (mid_tick),
        .bit_tick    (bit_tick),
        .div_pending (div_pending),
        .cfg_err     (cfg_err)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input int gap);
        logic m, b;
        k_model++;
        m = (k_model % OS) == OS / 2;
        b = (k_model % OS) == 0;
        exp_q.push_back({m, b, 32'(gap)});
    endtask

    // Load a divisor (counter paused), then realign and start counting.
    // On return we sit 1 ns after the realign edge E0.
    task automatic setup(input int di, input int df);
        div_wr   = 1'b1;
        div_int  = INT_W'(di);
        div_frac = FRAC_W'(df);
        tick();
        div_wr    = 1'b0;
        phase_clr = 1'b1;
        en        = 1'b1;
        tick();
        phase_clr = 1'b0;
        k_model   = 0;
    endtask

    // Wait for all expected ticks, bounded, then pause the counter.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout_left", exp_q.size(), 0);
        exp_q.delete();
        en = 1'b0;
        repeat (3) tick();
    endtask

    // Realign points: an edge that sampled phase_clr or a low reset.
    always @(posedge clk) begin
        ref_at_edge <= phase_clr || !reset;
    end

    // Monitor: compare each os_tick against the scoreboard head.
    always @(negedge clk) begin
        logic [33:0] e;
        cyc = cyc + 1;
        if (os_tick) begin
            span_last = cyc - last_ref;
            if (exp_q.size() == 0) begin
                check("extra_os_tick", 32'(os_tick), 0);
            end else begin
                e = exp_q.pop_front();
                check("os_gap", 32'(cyc - last_tick), e[31:0]);
                check("mid_tick", 32'(mid_tick), 32'(e[33]));
                check("bit_tick", 32'(bit_tick), 32'(e[32]));
            end
            last_tick = cyc;
        end else if (mid_tick || bit_tick) begin
            check("orphan_tick", 32'({mid_tick, bit_tick}), 0);
        end
        if (ref_at_edge) begin
            last_tick = cyc;
            last_ref  = cyc;
        end
    end

    initial begin
        // Reset state.
        en = 1'b1;
        repeat (3) tick();
        check("rst_os_tick", 32'(os_tick), 0);
        check("rst_mid_tick", 32'(mid_tick), 0);
        check("rst_bit_tick", 32'(bit_tick), 0);
        check("rst_div_pending", 32'(div_pending), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);

        // Defaults 325 + 8/16: first tick 325 cycles after release.
        k_model = 0;
        push_tick(325);
        push_tick(325);
        push_tick(326);
        push_tick(325);
        push_tick(326);
        reset = 1'b1;
        drain(2000);

        // Integer divisor 4: tick every 4, mid on 8th, bit on 16th, repeating.
        setup(4, 0);
        for (int i = 0; i < 32; i++) push_tick(4);
        drain(300);

        // Fractional 4 + 8/16. 16 ticks land 71 edges after the realign edge,
        // 72 cycles when the phase_clr cycle itself is counted.
        setup(4, 8);
        for (int i = 0; i < 16; i++) push_tick(frac_gaps[i]);
        drain(200);
        check("frac_span16", 32'(span_last + 1), 72);

        // Deferred update mid-interval, then a rejected write.
        setup(4, 0);
        push_tick(4);
        push_tick(4);
        push_tick(6);
        push_tick(6);
        push_tick(6);
        repeat (5) tick();
        div_wr = 1'b1; div_int = 16'd6; div_frac = 4'd0;
        tick();
        div_wr = 1'b0;
        check("pend_set", 32'(div_pending), 1);
        tick();
        check("pend_hold", 32'(div_pending), 1);
        tick();
        check("pend_clr_at_bnd", 32'(div_pending), 0);
        div_wr = 1'b1; div_int = 16'd1;
        tick();
        div_wr = 1'b0;
        check("bad_wr_cfg_err", 32'(cfg_err), 1);
        check("bad_wr_no_pend", 32'(div_pending), 0);
        tick();
        check("cfg_err_one_pulse", 32'(cfg_err), 0);
        drain(200);

        // Write coinciding with a boundary: old divisor for the next interval.
        setup(4, 0);
        push_tick(4);
        push_tick(4);
        push_tick(5);
        repeat (3) tick();
        div_wr = 1'b1; div_int = 16'd5; div_frac = 4'd0;
        tick();
        div_wr = 1'b0;
        check("pend_after_bnd_wr", 32'(div_pending), 1);
        repeat (4) tick();
        check("pend_clr_next_bnd", 32'(div_pending), 0);
        drain(200);

        // en=0 for 10 cycles mid-interval: interval resumes, stretched by 10.
        setup(4, 0);
        push_tick(4);
        push_tick(14);
        push_tick(4);
        repeat (5) tick();
        en = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        drain(200);

        // phase_clr on a boundary edge: no tick, next one act_int later.
        setup(4, 0);
        push_tick(4);
        push_tick(4);
        k_model = 0;
        push_tick(4);
        repeat (11) tick();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check("clr_bnd_no_tick", 32'(os_tick), 0);
        drain(200);

        // Async reset between edges, with a tick high and a write pending.
        setup(4, 0);
        repeat (3) tick();
        div_wr = 1'b1; div_int = 16'd7; div_frac = 4'd0;
        tick();
        div_wr = 1'b0;
        check("pre_rst_tick", 32'(os_tick), 1);
        check("pre_rst_pend", 32'(div_pending), 1);
        #1 reset = 1'b0;
        #1 check("async_rst_outs",
                 32'({os_tick, mid_tick, bit_tick, div_pending, cfg_err}), 0);
        k_model = 0;
        push_tick(325);
        push_tick(325);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_pend", 32'(div_pending), 0);
        drain(1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
